// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single SDRAM controller port.
// One transaction is in flight at a time and every grant is followed by one IDLE cycle.
module sdram_port_arbiter #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic [DATA_W-1:0]     s_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;

    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid && (!m1_valid || last_grant)) begin
                        state      <= GRANT0;
                        last_grant <= 1'b0;
                    end else if (m1_valid) begin
                        state      <= GRANT1;
                        last_grant <= 1'b1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (s_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A grant is never aborted: the owner's valid is not consulted once granted.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        case (state)
            GRANT0: begin
                s_valid  = 1'b1;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready;
            end
            GRANT1: begin
                s_valid  = 1'b1;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready;
            end
            default: ;
        endcase
    end

    assign m0_rdata = m0_ready ? s_rdata : '0;
    assign m1_rdata = m1_ready ? s_rdata : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: requester and controller models
// feed a scoreboard, with a vector table plus directed multi-cycle sequences.
module tb_sdram_port_arbiter;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          m0_valid, m1_valid;
    logic          m0_ready, m1_ready;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [SW-1:0] m0_wstrb, m1_wstrb;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_valid, s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [DW-1:0] s_rdata;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct {
        int   port;
        req_t r;
    } sb_t;

    typedef struct {
        logic          use0, use1;
        logic [AW-1:0] addr0, addr1;
        logic [DW-1:0] wdata0, wdata1;
        logic [SW-1:0] wstrb0, wstrb1;
        int            lat;
        int            exp_first;
    } vec_t;

    typedef enum {R_IDLE, R_G0, R_G1} ref_state_t;

    req_t       iss0[$], iss1[$];
    sb_t        sb[$];
    int         order[$];
    req_t       cur0, cur1;
    logic       act0, act1, rdy_seen0, rdy_seen1;
    logic       spurious, rand_lat, prev_s_valid;
    int         ctrl_cnt, ctrl_lat;
    int         cyc, issue_cyc0, rise_cyc;
    logic [DW-1:0] last_rdata0;
    ref_state_t ref_state;
    logic       ref_last;
    int         n_vec = 0;
    int         n_err = 0;
    vec_t       vecs[8];

    // Controller read data is a fixed function of address; 0x100 maps to 0xDEADBEEF.
    function automatic logic [DW-1:0] rd_pattern(logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {7'd0, a} ^ 32'h0000_0100;
    endfunction

    function automatic req_t mk_req(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
        req_t r;
        r.addr  = a;
        r.wdata = d;
        r.wstrb = s;
        return r;
    endfunction

    function automatic vec_t mk_vec(logic u0, logic [AW-1:0] a0, logic [DW-1:0] d0, logic [SW-1:0] s0,
                                    logic u1, logic [AW-1:0] a1, logic [DW-1:0] d1, logic [SW-1:0] s1,
                                    int lat, int first);
        vec_t v;
        v.use0 = u0; v.addr0 = a0; v.wdata0 = d0; v.wstrb0 = s0;
        v.use1 = u1; v.addr1 = a1; v.wdata1 = d1; v.wstrb1 = s1;
        v.lat = lat; v.exp_first = first;
        return v;
    endfunction

    function automatic int sb_find(int p);
        foreach (sb[k]) if (sb[k].port == p) return k;
        return -1;
    endfunction

    task automatic compare(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_timeout(string name);
        n_vec++;
        n_err++;
        $display("[TB] FAIL %s: got timeout, expected completion (cycle %0d)", name, cyc);
    endtask

    // Sampled 2 time units after the rising edge, after the controller model has responded.
    task automatic check_output();
        int idx, k;
        int gp;
        logic [DW-1:0] exp_r0, exp_r1;
        idx = -1;
        exp_r0 = '0;
        exp_r1 = '0;
        compare("s_valid", 64'(s_valid), 64'(ref_state != R_IDLE));
        if (s_valid === 1'b1 && prev_s_valid !== 1'b1) rise_cyc = cyc;
        prev_s_valid = s_valid;
        if (ref_state == R_IDLE) begin
            compare("idle_s_bus", 64'({s_addr, s_wdata, s_wstrb}), 64'd0);
            compare("idle_m0_ready", 64'(m0_ready), 64'd0);
            compare("idle_m1_ready", 64'(m1_ready), 64'd0);
        end else begin
            gp  = (ref_state == R_G1) ? 1 : 0;
            idx = sb_find(gp);
            if (idx < 0) begin
                fail_timeout("grant_owner_missing");
            end else begin
                compare("s_addr", 64'(s_addr), 64'(sb[idx].r.addr));
                compare("s_wdata", 64'(s_wdata), 64'(sb[idx].r.wdata));
                compare("s_wstrb", 64'(s_wstrb), 64'(sb[idx].r.wstrb));
                if (s_ready === 1'b1) begin
                    if (gp == 0) exp_r0 = rd_pattern(sb[idx].r.addr);
                    else         exp_r1 = rd_pattern(sb[idx].r.addr);
                end
            end
            compare("granted_ready", 64'(gp == 1 ? m1_ready : m0_ready), 64'(s_ready));
            compare("other_ready", 64'(gp == 1 ? m0_ready : m1_ready), 64'd0);
        end
        compare("m0_rdata", 64'(m0_rdata), 64'(exp_r0));
        compare("m1_rdata", 64'(m1_rdata), 64'(exp_r1));

        rdy_seen0 = (m0_ready === 1'b1);
        rdy_seen1 = (m1_ready === 1'b1);
        if (rdy_seen0) begin
            k = sb_find(0);
            if (k >= 0) sb.delete(k);
            order.push_back(0);
            last_rdata0 = m0_rdata;
        end
        if (rdy_seen1) begin
            k = sb_find(1);
            if (k >= 0) sb.delete(k);
            order.push_back(1);
        end

        case (ref_state)
            R_IDLE: begin
                if (m0_valid && m1_valid) begin
                    ref_state = ref_last ? R_G0 : R_G1;
                    ref_last  = !ref_last;
                end else if (m0_valid) begin
                    ref_state = R_G0;
                    ref_last  = 1'b0;
                end else if (m1_valid) begin
                    ref_state = R_G1;
                    ref_last  = 1'b1;
                end
            end
            default: if (s_ready === 1'b1) ref_state = R_IDLE;
        endcase
        if (!resetn) begin
            ref_state = R_IDLE;
            ref_last  = 1'b1;
        end
    endtask

    // One clock: requesters advance, controller responds, outputs checked.
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (act0 && rdy_seen0) begin act0 = 1'b0; m0_valid = 1'b0; end
        if (!act0) begin
            if (iss0.size() > 0) begin
                cur0 = iss0.pop_front();
                act0 = 1'b1; m0_valid = 1'b1; issue_cyc0 = cyc;
                m0_addr = cur0.addr; m0_wdata = cur0.wdata; m0_wstrb = cur0.wstrb;
                e.port = 0; e.r = cur0; sb.push_back(e);
            end else begin
                m0_addr = AW'($urandom); m0_wdata = $urandom; m0_wstrb = SW'($urandom);
            end
        end
        if (act1 && rdy_seen1) begin act1 = 1'b0; m1_valid = 1'b0; end
        if (!act1) begin
            if (iss1.size() > 0) begin
                cur1 = iss1.pop_front();
                act1 = 1'b1; m1_valid = 1'b1;
                m1_addr = cur1.addr; m1_wdata = cur1.wdata; m1_wstrb = cur1.wstrb;
                e.port = 1; e.r = cur1; sb.push_back(e);
            end else begin
                m1_addr = AW'($urandom); m1_wdata = $urandom; m1_wstrb = SW'($urandom);
            end
        end
        if (s_valid === 1'b1) begin
            if (ctrl_cnt >= ctrl_lat) begin
                s_ready = 1'b1; s_rdata = rd_pattern(s_addr); ctrl_cnt = 0;
                if (rand_lat) ctrl_lat = $urandom_range(0, 3);
            end else begin
                s_ready = 1'b0; s_rdata = $urandom; ctrl_cnt++;
            end
        end else begin
            ctrl_cnt = 0; s_ready = spurious; s_rdata = $urandom;
        end
        #1;
        check_output();
    endtask

    task automatic run_until_idle(string name, int budget);
        for (int n = 0; n < budget; n++) begin
            step();
            if (iss0.size() == 0 && iss1.size() == 0 && !act0 && !act1 && ref_state == R_IDLE) return;
        end
        fail_timeout(name);
    endtask

    task automatic wait_for_grant(string name, int budget);
        for (int n = 0; n < budget; n++) begin
            step();
            if (s_valid === 1'b1) return;
        end
        fail_timeout(name);
    endtask

    // Asynchronous reset pulse landing mid-cycle, followed by a model flush.
    task automatic reset_pulse();
        #3;
        resetn = 1'b0;
        #1;
        compare("rst_s_valid", 64'(s_valid), 64'd0);
        compare("rst_readies", 64'({m0_ready, m1_ready}), 64'd0);
        compare("rst_data", 64'({s_addr, s_wdata, s_wstrb}), 64'd0);
        compare("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);
        iss0.delete(); iss1.delete(); sb.delete();
        act0 = 1'b0; act1 = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        rdy_seen0 = 1'b0; rdy_seen1 = 1'b0;
        s_ready = 1'b0; spurious = 1'b0; ctrl_cnt = 0;
        ref_state = R_IDLE; ref_last = 1'b1;
        repeat (2) step();
        resetn = 1'b1;
    endtask

    task automatic apply_stimulus(vec_t v, string name);
        int c0, c1;
        order.delete();
        ctrl_lat = v.lat;
        if (v.use0) iss0.push_back(mk_req(v.addr0, v.wdata0, v.wstrb0));
        if (v.use1) iss1.push_back(mk_req(v.addr1, v.wdata1, v.wstrb1));
        run_until_idle(name, 64);
        c0 = 0; c1 = 0;
        foreach (order[k]) if (order[k] == 0) c0++; else c1++;
        if (order.size() > 0) compare({name, "_first"}, 64'(order[0]), 64'(v.exp_first));
        else fail_timeout({name, "_first"});
        compare({name, "_cnt0"}, 64'(c0), 64'(v.use0));
        compare({name, "_cnt1"}, 64'(c1), 64'(v.use1));
    endtask

    initial begin
        int c0, c1;
        vecs[0] = mk_vec(1, 25'h0000100, 32'h0,        4'b0000, 0, 25'h0,       32'h0,        4'b0000, 3, 0);
        vecs[1] = mk_vec(0, 25'h0,       32'h0,        4'b0000, 1, 25'h0002000, 32'h12345678, 4'b0011, 2, 1);
        vecs[2] = mk_vec(1, 25'h0000040, 32'h0,        4'b0000, 1, 25'h0000080, 32'hCAFEF00D, 4'b1111, 1, 0);
        vecs[3] = mk_vec(1, 25'h1FFFFFC, 32'hFFFFFFFF, 4'b1111, 1, 25'h0,       32'h0,        4'b0000, 0, 0);
        vecs[4] = mk_vec(0, 25'h0,       32'h0,        4'b0000, 1, 25'h1FFFFFF, 32'h0,        4'b0000, 4, 1);
        vecs[5] = mk_vec(1, 25'h0000010, 32'h80000000, 4'b1000, 1, 25'h0000014, 32'h00FF0000, 4'b0100, 2, 0);
        vecs[6] = mk_vec(1, 25'h0000200, 32'h0,        4'b0000, 0, 25'h0,       32'h0,        4'b0000, 0, 0);
        vecs[7] = mk_vec(1, 25'h0000300, 32'h0,        4'b0000, 1, 25'h0000304, 32'h5A5A5A5A, 4'b1111, 1, 1);

        resetn = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;
        act0 = 1'b0; act1 = 1'b0; rdy_seen0 = 1'b0; rdy_seen1 = 1'b0;
        spurious = 1'b0; rand_lat = 1'b0; prev_s_valid = 1'b0;
        ctrl_cnt = 0; ctrl_lat = 0; cyc = 0; issue_cyc0 = 0; rise_cyc = 0;
        last_rdata0 = '0;
        ref_state = R_IDLE; ref_last = 1'b1;
        repeat (3) step();
        resetn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                compare("vec0_rdata", 64'(last_rdata0), 64'h00000000DEADBEEF);
                compare("vec0_latency", 64'(rise_cyc - issue_cyc0), 64'd1);
            end
        end

        // Ties straight after reset: m0, then m1, then m0 again.
        reset_pulse();
        order.delete();
        ctrl_lat = 1;
        iss0.push_back(mk_req(25'h0000500, 32'h0, 4'b0000));
        iss1.push_back(mk_req(25'h0000600, 32'h0, 4'b0000));
        run_until_idle("tie_a", 64);
        iss0.push_back(mk_req(25'h0000504, 32'h11111111, 4'b0001));
        iss1.push_back(mk_req(25'h0000604, 32'h22222222, 4'b0010));
        run_until_idle("tie_b", 64);
        compare("tie_order_len", 64'(order.size()), 64'd4);
        if (order.size() == 4) begin
            compare("tie_order0", 64'(order[0]), 64'd0);
            compare("tie_order1", 64'(order[1]), 64'd1);
            compare("tie_order2", 64'(order[2]), 64'd0);
        end

        // Requester drops valid mid-grant; the grant still completes.
        order.delete();
        ctrl_lat = 4;
        iss0.push_back(mk_req(25'h0000700, 32'h0, 4'b0000));
        wait_for_grant("drop_grant", 16);
        m0_valid = 1'b0;
        run_until_idle("drop_done", 32);
        compare("drop_ready_count", 64'(order.size()), 64'd1);

        // Spurious controller completions while idle.
        order.delete();
        spurious = 1'b1;
        repeat (4) step();
        spurious = 1'b0;
        compare("spurious_ready_count", 64'(order.size()), 64'd0);

        // Reset in the middle of GRANT0, then a tie must go to m0.
        order.delete();
        ctrl_lat = 8;
        iss0.push_back(mk_req(25'h0000800, 32'h0, 4'b0000));
        wait_for_grant("midrst_grant", 16);
        step();
        reset_pulse();
        compare("midrst_no_ready", 64'(order.size()), 64'd0);
        ctrl_lat = 2;
        iss0.push_back(mk_req(25'h0000900, 32'h0, 4'b0000));
        iss1.push_back(mk_req(25'h0000A00, 32'h0, 4'b0000));
        run_until_idle("midrst_tie", 64);
        if (order.size() > 0) compare("midrst_tie_first", 64'(order[0]), 64'd0);
        else fail_timeout("midrst_tie_first");

        // Saturation: 8 back-to-back requests per requester must alternate.
        reset_pulse();
        order.delete();
        rand_lat = 1'b1;
        ctrl_lat = 1;
        for (int i = 0; i < 8; i++) begin
            iss0.push_back(mk_req(AW'(25'h0010000 + 4 * i), $urandom, SW'($urandom)));
            iss1.push_back(mk_req(AW'(25'h0020000 + 4 * i), $urandom, SW'($urandom)));
        end
        run_until_idle("sat", 400);
        rand_lat = 1'b0;
        compare("sat_len", 64'(order.size()), 64'd16);
        foreach (order[k]) compare($sformatf("sat_order%0d", k), 64'(order[k]), 64'(k % 2));
        c0 = 0; c1 = 0;
        foreach (order[k]) if (order[k] == 0) c0++; else c1++;
        compare("sat_cnt0", 64'(c0), 64'd8);
        compare("sat_cnt1", 64'(c1), 64'd8);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
